// File: rtl/joy_debounce_pkg.sv
// Shared constants for the joystick debouncer: channel indices, joystick bit
// positions and default timing parameters.
package joy_debounce_pkg;

    localparam int NUM_CH = 17;

    localparam int CH_SW0  = 0;
    localparam int CH_SW1  = 1;
    localparam int CH_SW2  = 2;
    localparam int CH_SW3  = 3;
    localparam int CH_SW4  = 4;
    localparam int CH_SW5  = 5;
    localparam int CH_SW7  = 6;
    localparam int CH_SW8  = 7;
    localparam int CH_SW9  = 8;
    localparam int CH_SW10 = 9;
    localparam int CH_SW11 = 10;
    localparam int CH_SW12 = 11;
    localparam int CH_SW16 = 12;
    localparam int CH_KEY0 = 13;
    localparam int CH_KEY1 = 14;
    localparam int CH_KEY2 = 15;
    localparam int CH_KEY3 = 16;

    // KEY channels are active-low buttons and get inverted after synchronization
    localparam logic [NUM_CH-1:0] CH_ACTIVE_LOW = 17'h1E000;

    localparam int JOY_R     = 0;
    localparam int JOY_L     = 1;
    localparam int JOY_D     = 2;
    localparam int JOY_U     = 3;
    localparam int JOY_A     = 4;
    localparam int JOY_B     = 5;
    localparam int JOY_C     = 6;
    localparam int JOY_START = 7;

    localparam int DB_TICK_DEFAULT  = 50000;
    localparam int DB_COUNT_DEFAULT = 5;

endpackage

// File: rtl/joy_debounce_bit.sv
// One debounced channel: 2-flop synchronizer, tick-driven stability counter
// and the accepted level.
module debounce_bit
    import joy_debounce_pkg::*;
#(
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic tick,
    input  logic polarity,
    output logic level
);

    logic       sync_0;
    logic       sync_1;
    logic       synced;
    logic [3:0] stable_cnt;

    assign synced = sync_1 ^ polarity;

    // A new level is accepted only after DB_COUNT consecutive mismatching ticks
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_0     <= 1'b0;
            sync_1     <= 1'b0;
            stable_cnt <= 4'd0;
            level      <= 1'b0;
        end else begin
            sync_0 <= raw;
            sync_1 <= sync_0;
            if (tick) begin
                if (synced == level) begin
                    stable_cnt <= 4'd0;
                end else if (stable_cnt == 4'(DB_COUNT - 1)) begin
                    level      <= ~level;
                    stable_cnt <= 4'd0;
                end else begin
                    stable_cnt <= stable_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/joy_debounce.sv
// Debounces the board switches and keys into two joystick words plus a user
// reset request, with a change pulse for any output update.
module joy_debounce
    import joy_debounce_pkg::*;
#(
    parameter int DB_TICK  = DB_TICK_DEFAULT,
    parameter int DB_COUNT = DB_COUNT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] SW,
    input  logic [3:0]  KEY,
    output logic [31:0] joy_0,
    output logic [31:0] joy_1,
    output logic        reset_req,
    output logic        joy_chg
);

    localparam int TICK_W = $clog2(DB_TICK);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [NUM_CH-1:0] raw_ch;
    logic [NUM_CH-1:0] level;
    logic [31:0]       next_0;
    logic [31:0]       next_1;
    logic              unused_sw;

    assign tick = (tick_cnt == TICK_W'(DB_TICK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Switches that are not wired to any function
    assign unused_sw = ^{SW[17], SW[15:13], SW[6]};

    always_comb begin
        raw_ch          = '0;
        raw_ch[CH_SW0]  = SW[0];
        raw_ch[CH_SW1]  = SW[1];
        raw_ch[CH_SW2]  = SW[2];
        raw_ch[CH_SW3]  = SW[3];
        raw_ch[CH_SW4]  = SW[4];
        raw_ch[CH_SW5]  = SW[5];
        raw_ch[CH_SW7]  = SW[7];
        raw_ch[CH_SW8]  = SW[8];
        raw_ch[CH_SW9]  = SW[9];
        raw_ch[CH_SW10] = SW[10];
        raw_ch[CH_SW11] = SW[11];
        raw_ch[CH_SW12] = SW[12];
        raw_ch[CH_SW16] = SW[16];
        raw_ch[CH_KEY0] = KEY[0];
        raw_ch[CH_KEY1] = KEY[1];
        raw_ch[CH_KEY2] = KEY[2];
        raw_ch[CH_KEY3] = KEY[3];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_bit #(
            .DB_COUNT (DB_COUNT)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw_ch[i]),
            .tick     (tick),
            .polarity (CH_ACTIVE_LOW[i]),
            .level    (level[i])
        );
    end

    always_comb begin
        next_0            = '0;
        next_0[JOY_R]     = level[CH_SW0];
        next_0[JOY_L]     = level[CH_SW3];
        next_0[JOY_D]     = level[CH_SW1];
        next_0[JOY_U]     = level[CH_SW2];
        next_0[JOY_A]     = level[CH_KEY2];
        next_0[JOY_B]     = level[CH_SW5];
        next_0[JOY_C]     = level[CH_SW4];
        next_0[JOY_START] = level[CH_KEY3];

        next_1            = '0;
        next_1[JOY_R]     = level[CH_SW7];
        next_1[JOY_L]     = level[CH_SW10];
        next_1[JOY_D]     = level[CH_SW8];
        next_1[JOY_U]     = level[CH_SW9];
        next_1[JOY_A]     = level[CH_KEY0];
        next_1[JOY_B]     = level[CH_SW12];
        next_1[JOY_C]     = level[CH_SW11];
        next_1[JOY_START] = level[CH_KEY1];
    end

    // joy_chg is registered alongside the words so it marks their update cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            joy_0     <= '0;
            joy_1     <= '0;
            reset_req <= 1'b0;
            joy_chg   <= 1'b0;
        end else begin
            joy_0     <= next_0;
            joy_1     <= next_1;
            reset_req <= level[CH_SW16];
            joy_chg   <= (next_0 != joy_0) || (next_1 != joy_1) ||
                         (level[CH_SW16] != reset_req);
        end
    end

endmodule

// File: tb/tb_joy_debounce.sv
// Self-checking bench for joy_debounce: vector table, directed corner cases
// and random stimulus against a history-based reference model.
module tb_joy_debounce;

    localparam int DB_TICK  = 4;
    localparam int DB_COUNT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] SW;
    logic [3:0]  KEY;
    logic [31:0] joy_0;
    logic [31:0] joy_1;
    logic        reset_req;
    logic        joy_chg;

    joy_debounce #(
        .DB_TICK  (DB_TICK),
        .DB_COUNT (DB_COUNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .SW        (SW),
        .KEY       (KEY),
        .joy_0     (joy_0),
        .joy_1     (joy_1),
        .reset_req (reset_req),
        .joy_chg   (joy_chg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int chg_pulses = 0;

    // Reference model: raw {KEY,SW} history, tick phase and per-line acceptance.
    // Lines 0..17 are SW bits, 18+k is "KEY[k] pressed".
    logic [21:0] hist_q[$];
    int          tcount = 0;
    bit          acc[22];
    int          streak[22];
    logic [31:0] m_j0 = '0;
    logic [31:0] m_j1 = '0;
    logic        m_rr = 1'b0;
    logic        m_chg = 1'b0;

    function automatic logic [31:0] model_word0();
        return {24'b0, acc[21], acc[4], acc[5], acc[20], acc[2], acc[1], acc[3], acc[0]};
    endfunction

    function automatic logic [31:0] model_word1();
        return {24'b0, acc[19], acc[11], acc[12], acc[18], acc[9], acc[8], acc[10], acc[7]};
    endfunction

    task automatic model_edge();
        logic [21:0] samp;
        logic [31:0] n0;
        logic [31:0] n1;
        logic        nrr;
        bit          tk;
        bit          lvl;
        if (reset) begin
            hist_q.delete();
            hist_q.push_back('0);
            hist_q.push_back('0);
            tcount = 0;
            for (int i = 0; i < 22; i++) begin
                acc[i] = 1'b0;
                streak[i] = 0;
            end
            m_j0 = '0;
            m_j1 = '0;
            m_rr = 1'b0;
            m_chg = 1'b0;
            return;
        end
        n0 = model_word0();
        n1 = model_word1();
        nrr = acc[16];
        m_chg = (n0 !== m_j0) || (n1 !== m_j1) || (nrr !== m_rr);
        m_j0 = n0;
        m_j1 = n1;
        m_rr = nrr;
        tk = (tcount == DB_TICK - 1);
        tcount = tk ? 0 : tcount + 1;
        if (tk) begin
            samp = hist_q[0];
            for (int i = 0; i < 22; i++) begin
                lvl = (i < 18) ? samp[i] : ~samp[i];
                if (lvl != acc[i]) begin
                    streak[i]++;
                    if (streak[i] == DB_COUNT) begin
                        acc[i] = ~acc[i];
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
        end
        hist_q.push_back({KEY, SW});
        if (hist_q.size() > 2) void'(hist_q.pop_front());
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [17:0] sw, input logic [3:0] key, input logic rst);
        SW = sw;
        KEY = key;
        reset = rst;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        checkOutput("joy_0", joy_0, m_j0);
        checkOutput("joy_1", joy_1, m_j1);
        checkOutput("reset_req", {31'b0, reset_req}, {31'b0, m_rr});
        checkOutput("joy_chg", {31'b0, joy_chg}, {31'b0, m_chg});
        if (joy_chg === 1'b1) chg_pulses++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic doReset(input int n);
        applyStimulus(18'h0, 4'hF, 1'b1);
        run(n);
        applyStimulus(18'h0, 4'hF, 1'b0);
    endtask

    typedef struct {
        logic [17:0] sw;
        logic [3:0]  key;
        logic [31:0] j0;
        logic [31:0] j1;
        logic        rr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        bit  got;
        bit  flag;
        logic [3:0] key;

        tbl[0] = '{18'h00000, 4'hF, 32'h00, 32'h00, 1'b0};
        tbl[1] = '{18'h00001, 4'hF, 32'h01, 32'h00, 1'b0};
        tbl[2] = '{18'h0003E, 4'hF, 32'h6E, 32'h00, 1'b0};
        tbl[3] = '{18'h00000, 4'h3, 32'h90, 32'h00, 1'b0};
        tbl[4] = '{18'h01F80, 4'hF, 32'h00, 32'h6F, 1'b0};
        tbl[5] = '{18'h00000, 4'hC, 32'h00, 32'h90, 1'b0};
        tbl[6] = '{18'h10000, 4'hF, 32'h00, 32'h00, 1'b1};
        tbl[7] = '{18'h2E040, 4'hF, 32'h00, 32'h00, 1'b0};
        tbl[8] = '{18'h3FFFF, 4'h0, 32'hFF, 32'hFF, 1'b1};

        // Reset state, then quiet for 100 cycles
        doReset(3);
        checkOutput("reset_joy_0", joy_0, 32'h0);
        checkOutput("reset_joy_1", joy_1, 32'h0);
        checkOutput("reset_req_rst", {31'b0, reset_req}, 32'h0);
        checkOutput("reset_chg", {31'b0, joy_chg}, 32'h0);
        chg_pulses = 0;
        run(100);
        checkOutput("idle_pulses", chg_pulses, 0);
        checkOutput("idle_joy_0", joy_0, 32'h0);

        // Clean press on SW[0]
        chg_pulses = 0;
        applyStimulus(18'h00001, 4'hF, 1'b0);
        got = 0;
        lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            step();
            if (joy_0 == 32'h01) begin
                got = 1;
                lat = i;
            end
        end
        checkOutput("press_seen", {31'b0, got}, 32'h1);
        checkOutput("press_latency_in_window", {31'b0, (lat >= 11 && lat <= 15)}, 32'h1);
        run(10);
        checkOutput("press_pulses", chg_pulses, 1);

        // Bounce on KEY[2]
        doReset(2);
        run(5);
        chg_pulses = 0;
        flag = 1;
        key = 4'hF;
        for (int p = 0; p < 8; p++) begin
            key[2] = ~key[2];
            applyStimulus(18'h0, key, 1'b0);
            for (int c = 0; c < 5; c++) begin
                step();
                if (joy_0[4] !== 1'b0) flag = 0;
            end
        end
        checkOutput("bounce_quiet", {31'b0, flag}, 32'h1);
        applyStimulus(18'h0, 4'hB, 1'b0);
        got = 0;
        for (int i = 1; i <= 15 && !got; i++) begin
            step();
            if (joy_0[4] === 1'b1) got = 1;
        end
        checkOutput("bounce_settled", {31'b0, got}, 32'h1);
        run(5);
        checkOutput("bounce_pulses", chg_pulses, 1);

        // Short glitch on SW[12]
        doReset(2);
        run(6);
        chg_pulses = 0;
        flag = 1;
        applyStimulus(18'h01000, 4'hF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            if (joy_1 !== 32'h0) flag = 0;
        end
        applyStimulus(18'h0, 4'hF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            if (joy_1 !== 32'h0) flag = 0;
        end
        checkOutput("glitch_joy_1", {31'b0, flag}, 32'h1);
        checkOutput("glitch_pulses", chg_pulses, 0);

        // SW[16] and KEY[1] together
        doReset(2);
        run(6);
        chg_pulses = 0;
        applyStimulus(18'h10000, 4'hD, 1'b0);
        got = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            step();
            if (reset_req === 1'b1) got = 1;
        end
        checkOutput("simul_seen", {31'b0, got}, 32'h1);
        checkOutput("simul_joy_1", joy_1, 32'h80);
        run(10);
        checkOutput("simul_pulses", chg_pulses, 1);

        // Reset in the middle of a count on SW[7]
        doReset(2);
        run(6);
        applyStimulus(18'h00080, 4'hF, 1'b0);
        run(10);
        checkOutput("midreset_pre", {31'b0, joy_1[0]}, 32'h0);
        applyStimulus(18'h00080, 4'hF, 1'b1);
        step();
        applyStimulus(18'h00080, 4'hF, 1'b0);
        lat = 0;
        for (int i = 1; i <= 25 && lat == 0; i++) begin
            step();
            if (joy_1[0] === 1'b1) lat = i;
        end
        checkOutput("midreset_latency", lat, 3 * DB_TICK + 1);

        // Steady-state vector table
        doReset(2);
        for (int v = 0; v < 9; v++) begin
            applyStimulus(tbl[v].sw, tbl[v].key, 1'b0);
            run(20);
            checkOutput($sformatf("vec%0d_joy_0", v), joy_0, tbl[v].j0);
            checkOutput($sformatf("vec%0d_joy_1", v), joy_1, tbl[v].j1);
            checkOutput($sformatf("vec%0d_rr", v), {31'b0, reset_req}, {31'b0, tbl[v].rr});
        end

        // Random stimulus against the model
        for (int s = 0; s < 60; s++) begin
            applyStimulus(18'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0));
            run($urandom_range(1, 20));
        end
        applyStimulus(18'h0, 4'hF, 1'b0);
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
